// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the jtdsp16 blocks: controller state type and default RAM geometry.
package jtdsp16_pkg;

    localparam int DPRAM_DW = 16;
    localparam int DPRAM_AW = 11;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } dpram_state_e;

endpackage

// File: rtl/jtdsp16_dpram_clr.sv
// Clear sequencer for jtdsp16_dpram: sweeps every address once, starting at 0,
// after reset or on a clr request taken in IDLE.
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | writing the clear value at cnt_q, one word per cycle
// IDLE  | array free for user reads/writes; clr restarts the sweep
module jtdsp16_dpram_clr
    import jtdsp16_pkg::*;
#(
    parameter int AW = DPRAM_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    output logic [AW-1:0] clr_addr,
    output logic          clr_we
);

    dpram_state_e  state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                // the last word is written on the same edge that leaves CLEAR
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_addr = cnt_q;
    assign clr_we   = (state_q == CLEAR);

endmodule

// File: rtl/jtdsp16_dpram.sv
// Simple dual-port RAM with a self-clearing sequencer and registered read port.
// Define JTDSP16_DPRAM_BYPASS_EN to return new data on same-address read-during-write.
module jtdsp16_dpram
    import jtdsp16_pkg::*;
#(
    parameter int            DW     = DPRAM_DW,
    parameter int            AW     = DPRAM_AW,
    parameter logic [DW-1:0] CLRVAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] din,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] dout,
    output logic          dout_ok
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    logic          seq_busy;
    logic [AW-1:0] seq_addr;
    logic          seq_we;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] rd_word;
    logic          rd_en;

    logic [DW-1:0] dout_q;
    logic          ok_q;

    jtdsp16_dpram_clr #(
        .AW (AW)
    ) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (seq_busy),
        .clr_addr (seq_addr),
        .clr_we   (seq_we)
    );

    // While the sequencer owns the array, user requests never reach it; reset blocks all writes.
    assign mem_we   = rst_n & (seq_busy ? seq_we : we);
    assign mem_addr = seq_busy ? seq_addr : waddr;
    assign mem_din  = seq_busy ? CLRVAL : din;
    assign rd_en    = re & ~seq_busy;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_din;
        end
    end

`ifdef JTDSP16_DPRAM_BYPASS_EN
    assign rd_word = (we && (waddr == raddr)) ? din : mem_q[raddr];
`else
    assign rd_word = mem_q[raddr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            ok_q   <= 1'b0;
        end else begin
            ok_q <= rd_en;
            if (rd_en) begin
                dout_q <= rd_word;
            end
        end
    end

    assign busy    = seq_busy;
    assign dout    = dout_q;
    assign dout_ok = ok_q;

endmodule

// File: tb/tb_jtdsp16_dpram.sv
// Self-checking bench for jtdsp16_dpram: directed table, corner sequences and randomized traffic.
module tb_jtdsp16_dpram;

    localparam int          DW    = 16;
    localparam int          AW    = 11;
    localparam int          DEPTH = 2048;
    localparam logic [15:0] CLRV  = 16'h0000;
`ifdef JTDSP16_DPRAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          busy;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;
    logic          re;
    logic [AW-1:0] raddr;
    logic [DW-1:0] dout;
    logic          dout_ok;

    jtdsp16_dpram #(
        .DW     (DW),
        .AW     (AW),
        .CLRVAL (CLRV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .busy    (busy),
        .we      (we),
        .waddr   (waddr),
        .din     (din),
        .re      (re),
        .raddr   (raddr),
        .dout    (dout),
        .dout_ok (dout_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word array plus "clear cycles remaining".
    logic [DW-1:0] mem_m [DEPTH];
    int            clr_left;
    logic [DW-1:0] exp_dout;
    logic          exp_ok;

    int n_vec;
    int n_err;

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] din;
        logic          re;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp_dout;
        logic          exp_ok;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        clr_left = DEPTH;
        exp_dout = '0;
        exp_ok   = 1'b0;
    endtask

    task automatic model_edge();
        if (clr_left > 0) begin
            clr_left--;
            exp_ok = 1'b0;
            if (clr_left == 0) begin
                for (int i = 0; i < DEPTH; i++) mem_m[i] = CLRV;
            end
        end else begin
            exp_ok = re;
            if (re) begin
                if (we && (waddr == raddr)) exp_dout = BYP ? din : mem_m[raddr];
                else                        exp_dout = mem_m[raddr];
            end
            if (we)  mem_m[waddr] = din;
            if (clr) clr_left = DEPTH;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        chk("busy",    {31'd0, busy},    {31'd0, (clr_left > 0)});
        chk("dout",    {16'd0, dout},    {16'd0, exp_dout});
        chk("dout_ok", {31'd0, dout_ok}, {31'd0, exp_ok});
    endtask

    task automatic idle_in();
        we = 1'b0; re = 1'b0; clr = 1'b0;
        waddr = '0; raddr = '0; din = '0;
    endtask

    task automatic rand_in(input bit with_clr);
        we    = 1'($urandom_range(0, 1));
        re    = 1'($urandom_range(0, 1));
        waddr = AW'($urandom_range(0, 15));
        raddr = AW'($urandom_range(0, 15));
        din   = DW'($urandom);
        clr   = with_clr ? ($urandom_range(0, 199) == 0) : 1'b0;
    endtask

    // mode 0: quiet inputs, 1: random we/re/clr noise, 2: periodic clr pulses
    task automatic wait_clear(input int mode, output int n);
        n = 0;
        while (busy && n < 5000) begin
            if (mode == 1) begin
                we = 1'($urandom_range(0, 1));
                re = 1'($urandom_range(0, 1));
                waddr = AW'($urandom);
                raddr = AW'($urandom);
                din = DW'($urandom);
                clr = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                clr = (n % 100 == 7);
            end
            cyc();
            n++;
        end
        idle_in();
    endtask

    initial begin
        int n;
        logic [AW-1:0] a;
        logic [AW-1:0] rd_addrs [3];

        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;

        tbl[0] = '{1'b1, 11'h123, 16'hBEEF, 1'b0, 11'h000, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 11'h000, 16'h0000, 1'b1, 11'h123, 16'hBEEF, 1'b1};
        tbl[2] = '{1'b1, 11'h055, 16'h1234, 1'b1, 11'h055, BYP ? 16'h1234 : 16'h0000, 1'b1};
        tbl[3] = '{1'b0, 11'h000, 16'h0000, 1'b1, 11'h055, 16'h1234, 1'b1};
        tbl[4] = '{1'b0, 11'h000, 16'h0000, 1'b0, 11'h055, 16'h1234, 1'b0};
        tbl[5] = '{1'b1, 11'h200, 16'h5A5A, 1'b1, 11'h123, 16'hBEEF, 1'b1};
        tbl[6] = '{1'b0, 11'h000, 16'h0000, 1'b1, 11'h200, 16'h5A5A, 1'b1};
        tbl[7] = '{1'b0, 11'h000, 16'h0000, 1'b1, 11'h000, 16'h0000, 1'b1};

        rd_addrs[0] = 11'h000;
        rd_addrs[1] = 11'h3FF;
        rd_addrs[2] = 11'h7FF;

        // Power-on reset and automatic clear
        rst_n = 1'b0;
        idle_in();
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
        wait_clear(0, n);
        chk("init_clear_len", n, 2048);

        foreach (rd_addrs[k]) begin
            a = rd_addrs[k];
            re = 1'b1;
            raddr = a;
            cyc();
            chk("clr_read_dout", {16'd0, dout}, {16'd0, CLRV});
            chk("clr_read_ok", {31'd0, dout_ok}, 32'd1);
        end
        idle_in();

        // Directed table
        for (int i = 0; i < 8; i++) begin
            we = tbl[i].we; waddr = tbl[i].waddr; din = tbl[i].din;
            re = tbl[i].re; raddr = tbl[i].raddr; clr = 1'b0;
            cyc();
            chk($sformatf("tbl%0d_dout", i), {16'd0, dout}, {16'd0, tbl[i].exp_dout});
            chk($sformatf("tbl%0d_ok", i), {31'd0, dout_ok}, {31'd0, tbl[i].exp_ok});
        end
        idle_in();

        // Back-to-back reads keep dout_ok high
        for (int i = 0; i < 4; i++) begin
            re = 1'b1;
            raddr = (i % 2 == 0) ? 11'h123 : 11'h200;
            cyc();
            chk("b2b_ok", {31'd0, dout_ok}, 32'd1);
        end
        idle_in();

        // Randomized traffic on a narrow address window
        for (int i = 0; i < 400; i++) begin
            rand_in(1'b1);
            cyc();
        end
        idle_in();
        if (busy) wait_clear(1, n);
        idle_in();

        // Explicit clear with traffic ignored while busy
        we = 1'b1; waddr = 11'h010; din = 16'hA5A5;
        cyc();
        idle_in();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        wait_clear(1, n);
        chk("clr_req_len", n, 2048);
        re = 1'b1; raddr = 11'h010;
        cyc();
        chk("clr_req_read", {16'd0, dout}, {16'd0, CLRV});
        chk("clr_req_ok", {31'd0, dout_ok}, 32'd1);
        idle_in();

        // Reset mid-read: dout and dout_ok drop at once
        we = 1'b1; waddr = 11'h300; din = 16'hCAFE;
        cyc();
        we = 1'b0; re = 1'b1; raddr = 11'h300;
        cyc();
        chk("pre_rst_dout", {16'd0, dout}, 32'h0000CAFE);
        idle_in();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_read_dout", {16'd0, dout}, 32'd0);
        chk("rst_read_ok", {31'd0, dout_ok}, 32'd0);
        chk("rst_read_busy", {31'd0, busy}, 32'd1);
        repeat (2) cyc();
        rst_n = 1'b1;

        // Reset at clear count 500, then a fresh full clear despite clr pulses
        repeat (500) cyc();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_clr_busy", {31'd0, busy}, 32'd1);
        repeat (2) cyc();
        rst_n = 1'b1;
        wait_clear(2, n);
        chk("restart_clear_len", n, 2048);
        re = 1'b1; raddr = 11'h300;
        cyc();
        chk("restart_read", {16'd0, dout}, {16'd0, CLRV});
        idle_in();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
